// File: rtl/palette_ram_ctrl.sv
// Writable NES palette RAM: copies its power-up contents from a palette ROM, then serves render reads and register writes.
// Optional greyscale masking of read data is enabled by defining PALETTE_GREYSCALE_EN.
module palette_ram_ctrl #(
  parameter int DW     = 8,
  parameter int AW     = 5,
  parameter int MIRROR = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [AW-1:0] rom_addr_o,
  input  logic [DW-1:0] rom_dout_i,
  output logic          init_done_o,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
`ifdef PALETTE_GREYSCALE_EN
  input  logic          grey_i,
`endif
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;
`ifdef PALETTE_GREYSCALE_EN
  localparam logic [DW-1:0] GREY_MASK = {{(DW-4){1'b1}}, 4'b0000};
`endif

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Background-colour slots 0x10/0x14/0x18/0x1C share storage with 0x00/0x04/0x08/0x0C.
  function automatic logic is_alias(input logic [AW-1:0] a);
    logic r;
    r = 1'b0;
    if (MIRROR == 1 && AW == 5) begin
      if (a[AW-1] && (a[1:0] == 2'b00)) r = 1'b1;
      else r = 1'b0;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] phys(input logic [AW-1:0] a);
    logic [AW-1:0] p;
    p = a;
    if (is_alias(a)) p[AW-1] = 1'b0;
    else p = a;
    return p;
  endfunction

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] rom_addr_q;
  logic          init_done_q;
  logic          wr_ready_q;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] load_idx_d;
  logic [AW-1:0] rd_phys_d;
  logic [AW-1:0] wr_phys_d;
  logic          load_we_d;
  logic          wr_acc_d;
  logic          mem_we_d;
  logic [AW-1:0] mem_waddr_d;
  logic [DW-1:0] mem_wdata_d;
  logic [DW-1:0] rd_word_d;

  // Write-port arbitration and read-data selection.
  always_comb begin
    // ROM data arriving now belongs to the address issued one cycle earlier.
    load_idx_d = cnt_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
    rd_phys_d  = phys(rd_addr_i);
    wr_phys_d  = phys(wr_addr_i);
    load_we_d  = (state_q == S_LOAD) && (cnt_q != {CW{1'b0}}) && !is_alias(load_idx_d);
    wr_acc_d   = (state_q == S_RUN) && wr_valid_i;
    if (load_we_d) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = load_idx_d;
      mem_wdata_d = rom_dout_i;
    end else if (wr_acc_d) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = wr_phys_d;
      mem_wdata_d = wr_data_i;
    end else begin
      mem_we_d    = 1'b0;
      mem_waddr_d = {AW{1'b0}};
      mem_wdata_d = {DW{1'b0}};
    end
    if (wr_acc_d && (wr_phys_d == rd_phys_d)) rd_word_d = wr_data_i;
    else rd_word_d = mem_q[rd_phys_d];
`ifdef PALETTE_GREYSCALE_EN
    if (grey_i) rd_word_d = rd_word_d & GREY_MASK;
    else rd_word_d = rd_word_d;
`endif
  end

  // Palette storage; deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
  end

  // Control FSM: ROM copy, then read/write service.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_LOAD;
      cnt_q       <= {CW{1'b0}};
      rom_addr_q  <= {AW{1'b0}};
      init_done_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= {DW{1'b0}};
    end else begin
      case (state_q)
        S_LOAD: begin
          rd_valid_q <= 1'b0;
          if (cnt_q == CW'(DEPTH)) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
            wr_ready_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q < CW'(DEPTH - 1)) rom_addr_q <= cnt_q[AW-1:0] + AW'(1);
            else rom_addr_q <= rom_addr_q;
          end
        end
        S_RUN: begin
          rd_valid_q <= rd_en_i;
          if (rd_en_i) rd_data_q <= rd_word_d;
          else rd_data_q <= rd_data_q;
        end
        default: begin
          state_q     <= S_LOAD;
          cnt_q       <= {CW{1'b0}};
          rom_addr_q  <= {AW{1'b0}};
          init_done_q <= 1'b0;
          wr_ready_q  <= 1'b0;
          rd_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign init_done_o = init_done_q;
  assign wr_ready_o  = wr_ready_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_palette_ram_ctrl.sv
// Directed bench for palette_ram_ctrl: a mirrored and a flat instance share stimulus, each with its own ROM model.
module tb_palette_ram_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_valid;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [4:0] rd_addr;
`ifdef PALETTE_GREYSCALE_EN
  logic       grey;
`endif
  logic [4:0] rom_addr_m, rom_addr_f;
  logic [7:0] rom_dout_m, rom_dout_f;
  logic       init_done_m, init_done_f, wr_ready_m, wr_ready_f;
  logic       rd_valid_m, rd_valid_f;
  logic [7:0] rd_data_m, rd_data_f;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] model [32];

  typedef struct {
    logic       wv;
    logic [4:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [4:0] ra;
    logic       ev;
    logic [7:0] ed_m;
    logic [7:0] ed_f;
  } vec_t;
  vec_t vecs [13];

  palette_ram_ctrl #(.DW(8), .AW(5), .MIRROR(1)) u_dut_m (
    .clk_i(clk), .rst_i(rst), .rom_addr_o(rom_addr_m), .rom_dout_i(rom_dout_m),
    .init_done_o(init_done_m), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_m),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
`ifdef PALETTE_GREYSCALE_EN
    .grey_i(grey),
`endif
    .rd_data_o(rd_data_m), .rd_valid_o(rd_valid_m));

  palette_ram_ctrl #(.DW(8), .AW(5), .MIRROR(0)) u_dut_f (
    .clk_i(clk), .rst_i(rst), .rom_addr_o(rom_addr_f), .rom_dout_i(rom_dout_f),
    .init_done_o(init_done_f), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_f),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
`ifdef PALETTE_GREYSCALE_EN
    .grey_i(grey),
`endif
    .rd_data_o(rd_data_f), .rd_valid_o(rd_valid_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [4:0] a);
    case (a)
      5'h00:   return 8'h31;
      5'h01:   return 8'h1B;
      5'h02:   return 8'h2B;
      5'h03:   return 8'h37;
      5'h10:   return 8'h99;
      5'h11:   return 8'h12;
      default: return 8'h40 + {3'b000, a};
    endcase
  endfunction

  function automatic logic [4:0] bphys(input logic [4:0] a);
    if (a[4] && a[1:0] == 2'b00) return {1'b0, a[3:0]};
    else return a;
  endfunction

  // Registered ROMs with one cycle of latency.
  always @(posedge clk) begin
    rom_dout_m <= rom_val(rom_addr_m);
    rom_dout_f <= rom_val(rom_addr_f);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Releases reset while hammering both ports, and times the copy.
  task automatic wait_init(input string tag);
    int  k;
    bit  done, rv_seen, wr_seen;
    k = 0; done = 1'b0; rv_seen = 1'b0; wr_seen = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'h00; wr_data = 8'h77; rd_en = 1'b1; rd_addr = 5'h01;
    rst = 1'b0;
    while (!done && k < 40) begin
      step();
      k++;
      if (rd_valid_m || rd_valid_f) rv_seen = 1'b1;
      if ((wr_ready_m && !init_done_m) || (wr_ready_f && !init_done_f)) wr_seen = 1'b1;
      if (init_done_m) done = 1'b1;
    end
    wr_valid = 1'b0; rd_en = 1'b0;
    check({tag, " init_cycles"}, k, 33);
    check({tag, " init_done_f"}, init_done_f, 1);
    check({tag, " wr_ready_m"}, wr_ready_m, 1);
    check({tag, " rom_addr_hold"}, rom_addr_m, 31);
    check({tag, " rd_valid_in_load"}, rv_seen, 0);
    check({tag, " wr_ready_in_load"}, wr_seen, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h00, 1'b1, 8'h31, 8'h31};
    vecs[1]  = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h03, 1'b1, 8'h37, 8'h37};
    vecs[2]  = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h11, 1'b1, 8'h12, 8'h12};
    vecs[3]  = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h10, 1'b1, 8'h31, 8'h99};
    vecs[4]  = '{1'b1, 5'h14, 8'h0F, 1'b0, 5'h00, 1'b0, 8'h31, 8'h99};
    vecs[5]  = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h04, 1'b1, 8'h0F, 8'h44};
    vecs[6]  = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h14, 1'b1, 8'h0F, 8'h0F};
    vecs[7]  = '{1'b1, 5'h09, 8'h2A, 1'b1, 5'h09, 1'b1, 8'h2A, 8'h2A};
    vecs[8]  = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h09, 1'b1, 8'h2A, 8'h2A};
    vecs[9]  = '{1'b1, 5'h1C, 8'h3C, 1'b1, 5'h0C, 1'b1, 8'h3C, 8'h4C};
    vecs[10] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h1F, 1'b1, 8'h5F, 8'h5F};
    vecs[11] = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 1'b0, 8'h5F, 8'h5F};
    vecs[12] = '{1'b1, 5'h05, 8'h27, 1'b1, 5'h05, 1'b1, 8'h27, 8'h27};
    for (int a = 0; a < 32; a++) model[a] = rom_val(5'(a));

    rst = 1'b1; wr_valid = 1'b0; wr_addr = 5'h00; wr_data = 8'h00; rd_en = 1'b0; rd_addr = 5'h00;
`ifdef PALETTE_GREYSCALE_EN
    grey = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst init_done", init_done_m, 0);
    check("rst wr_ready", wr_ready_m, 0);
    check("rst rd_valid", rd_valid_m, 0);
    check("rst rd_data", rd_data_m, 8'h00);
    check("rst rom_addr", rom_addr_m, 0);
    wait_init("por");

    // Reset in the middle of the copy, after ten issue cycles.
    rst = 1'b1;
    step();
    check("rerun init_done_drop", init_done_m, 0);
    rst = 1'b0;
    repeat (10) step();
    check("midload rom_addr", rom_addr_m, 10);
    rst = 1'b1;
    step();
    check("midload rom_addr_rst", rom_addr_m, 0);
    check("midload init_done", init_done_m, 0);
    wait_init("midload");

    for (int i = 0; i < 13; i++) begin
      wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].re; rd_addr = vecs[i].ra;
      step();
      if (vecs[i].wv) model[bphys(vecs[i].wa)] = vecs[i].wd;
      check($sformatf("vec%0d rd_valid_m", i), rd_valid_m, vecs[i].ev);
      check($sformatf("vec%0d rd_data_m", i), rd_data_m, vecs[i].ed_m);
      check($sformatf("vec%0d rd_valid_f", i), rd_valid_f, vecs[i].ev);
      check($sformatf("vec%0d rd_data_f", i), rd_data_f, vecs[i].ed_f);
    end
    wr_valid = 1'b0;

    // Back-to-back reads across the whole palette.
    for (int i = 0; i <= 32; i++) begin
      rd_en = (i < 32); rd_addr = 5'(i);
      step();
      if (i < 32) begin
        check($sformatf("stream%0d valid", i), rd_valid_m, 1);
        check($sformatf("stream%0d data", i), rd_data_m, model[bphys(5'(i))]);
      end else begin
        check("stream end valid", rd_valid_m, 0);
      end
    end

    // Reset during normal traffic must restore ROM contents.
    wr_valid = 1'b1; wr_addr = 5'h01; wr_data = 8'h05; rd_en = 1'b0;
    step();
    wr_valid = 1'b0; rd_en = 1'b1; rd_addr = 5'h01;
    step();
    check("run rd 01 before rst", rd_data_m, 8'h05);
    rd_en = 1'b0; rst = 1'b1;
    step();
    check("run rst init_done", init_done_m, 0);
    check("run rst wr_ready", wr_ready_m, 0);
    check("run rst rd_data", rd_data_m, 8'h00);
    wait_init("run");
    rd_en = 1'b1; rd_addr = 5'h01;
    step();
    check("post rst 01 m", rd_data_m, 8'h1B);
    check("post rst 01 f", rd_data_f, 8'h1B);
    rd_addr = 5'h14;
    step();
    check("post rst 14 m", rd_data_m, 8'h44);
    rd_en = 1'b0;

`ifdef PALETTE_GREYSCALE_EN
    wr_valid = 1'b1; wr_addr = 5'h05; wr_data = 8'h27;
    step();
    wr_valid = 1'b0; rd_en = 1'b1; rd_addr = 5'h05; grey = 1'b1;
    step();
    check("grey on", rd_data_m, 8'h20);
    grey = 1'b0;
    step();
    check("grey off", rd_data_m, 8'h27);
    wr_valid = 1'b1; wr_addr = 5'h06; wr_data = 8'h3F; rd_addr = 5'h06; grey = 1'b1;
    step();
    check("grey bypass", rd_data_m, 8'h30);
    wr_valid = 1'b0; rd_en = 1'b0; grey = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/palette_ram_ctrl.md
Name: palette_ram_ctrl

Overview:
Writable NES PPU palette memory, the successor to the fixed per-game palette ROMs. After reset it copies its initial contents from an external palette ROM, one entry per cycle. It then serves a render-side read port and a CPU/PPU-register-side write port. It applies NES palette mirroring, where entries 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C. It sits between the palette ROM and the pixel colour lookup in the PPU render pipeline.

Parameters:
DW, 8, palette entry data width in bits (the NES colour index occupies bits [5:0]).
AW, 5, address width; DEPTH = 2**AW entries.
MIRROR, 1, 1 = apply NES alias rule (only meaningful when AW = 5); 0 = flat memory.

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous reset, active-high
rom_addr  out  AW  address to external palette ROM (ROM has 1-cycle registered latency)
rom_dout  in  DW  data from external palette ROM
init_done  out  1  high once the initial copy is complete
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  AW  write address (logical, pre-mirroring)
wr_data  in  DW  write data
rd_en  in  1  read request
rd_addr  in  AW  read address (logical, pre-mirroring)
rd_data  out  DW  read data, one cycle after rd_en
rd_valid  out  1  qualifies rd_data
grey  in  1  greyscale request (exists only with GREYSCALE_EN)

Behaviour:
- Address mapping: phys(a) = a with bit 4 cleared when MIRROR=1, AW=5, a[4]=1 and a[1:0]=0; otherwise phys(a) = a. The mapping applies to reads and writes.
- FSM states are LOAD and RUN.
- Reset (rst high at a clock edge):
  - state <= LOAD, cnt <= 0, init_done <= 0, wr_ready <= 0, rd_valid <= 0, rd_data <= 0, rom_addr <= 0.
  - Memory contents are not cleared.
  - Reset has the same effect in any state, including mid-LOAD or during RUN traffic; the copy restarts from entry 0.
- LOAD:
  - Each cycle, rom_addr = cnt and cnt increments.
  - The data returned for address k (arriving the following cycle) is written to entry k.
  - Exception: when MIRROR=1, returned data for aliased addresses 0x10/0x14/0x18/0x1C is discarded, so the ROM's 0x00/0x04/0x08/0x0C values win.
  - The last write occurs DEPTH+1 cycles after reset deassertion. On that same edge the state becomes RUN, and init_done and wr_ready go high.
  - rd_en and wr_valid are ignored during LOAD; rd_valid stays 0.
  - rom_addr holds DEPTH-1 after the last issue.
- RUN:
  - wr_ready = 1 continuously. An accepted write updates mem[phys(wr_addr)] at that edge.
  - rd_en at cycle t gives rd_data = mem[phys(rd_addr)] and rd_valid = 1 at cycle t+1.
  - With no rd_en, rd_valid = 0 and rd_data holds its last value.
  - Read/write in the same cycle to the same physical entry is write-first: rd_data returns the new wr_data.
  - An accepted write to an aliased address updates the shared entry, so both logical addresses read back the new value.
- No backpressure on reads; one read per cycle sustained.
- Widths: all data paths are DW bits, with no truncation or extension; cnt is AW+1 bits to detect completion.

Optional Feature:
- Macro: PALETTE_GREYSCALE_EN.
- Defined:
  - The grey port exists and is sampled together with rd_en.
  - When grey = 1, rd_data = mem value with bits [3:0] forced to 0; bits [DW-1:4] pass through (NES PPUMASK greyscale).
  - Write-first bypass data is masked the same way.
- Not defined: the grey port is absent and rd_data is unmasked.

Test Plan:
- Reset-time copy:
  - Stimulus: ROM model returns 0x31,0x1B,0x2B,0x37 at 0x00-0x03, 0x12 at 0x11 and 0x99 at 0x10; release rst.
  - Required: init_done rises exactly DEPTH+1 = 33 cycles later; reads give 0x00->0x31, 0x03->0x37, 0x11->0x12, 0x10->0x31 (0x99 discarded).
- Mirroring on write:
  - Stimulus: write 0x0F to 0x14, then read 0x04 and 0x14.
  - Required: both return 0x0F; with MIRROR=0, 0x04 keeps its ROM value.
- Read latency and streaming:
  - Stimulus: rd_en held high for addresses 0x00..0x1F on consecutive cycles.
  - Required: rd_valid high for 32 consecutive cycles, starting one cycle after the first rd_en, with data in address order.
- Collision:
  - Stimulus: same-cycle write 0x2A to 0x09 and read of 0x09.
  - Required: rd_data = 0x2A next cycle.
- Reset mid-operation:
  - Stimulus: assert rst during LOAD at cnt = 10, and again during RUN after writing 0x05 to 0x01.
  - Required: each time, init_done drops, the copy restarts, and 0x01 ends holding the ROM value 0x1B; wr_valid is ignored while wr_ready = 0.
- Greyscale (PALETTE_GREYSCALE_EN):
  - Stimulus: read entry holding 0x27 with grey = 1, then grey = 0.
  - Required: returns 0x20, then 0x27.
